// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: load/store widths, FSM states, RAM strobe levels.
// S_TURN exists only when WRITE_TURNAROUND_EN is defined.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        MemOpB  = 3'b000,
        MemOpH  = 3'b001,
        MemOpW  = 3'b010,
        MemOpBU = 3'b100,
        MemOpHU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1
`ifdef WRITE_TURNAROUND_EN
        ,
        S_TURN  = 2'd2
`endif
    } state_e;

    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store lane replication, load extraction/extension,
// and alignment/opcode checking for one MEM access.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        addr_err_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata_i[{addr_i, 3'b000} +: 8];
        half_lane  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sel_o      = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        addr_err_o = 1'b0;
        case (op_i)
            MemOpB, MemOpBU: begin
                sel_o   = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (op_i == MemOpB) ? {{24{byte_lane[7]}}, byte_lane}
                                           : {24'h0, byte_lane};
            end
            MemOpH, MemOpHU: begin
                sel_o      = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = (op_i == MemOpH) ? {{16{half_lane[15]}}, half_lane}
                                              : {16'h0, half_lane};
                addr_err_o = addr_i[0];
            end
            MemOpW: begin
                sel_o      = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
                addr_err_o = |addr_i;
            end
            default: addr_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between IF and MEM; a MEM access stalls the pipe one cycle and
// IF is served in the following slot. Define WRITE_TURNAROUND_EN for an idle cycle after stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_inst_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              addr_err_o,
    output logic              stall_req_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    state_e      state_q, state_d;
    logic [31:0] rdata_q;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata, lane_rdata;
    logic        lane_err, mem_valid;
    logic        unused;

    mem_lane_align u_lane (
        .op_i       (mem_op_i),
        .addr_i     (mem_addr_i[1:0]),
        .wdata_i    (mem_data_i),
        .rdata_i    (ram_rdata_i),
        .sel_o      (lane_sel),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .addr_err_o (lane_err)
    );

    assign mem_valid  = mem_ce_i & ~lane_err;
    assign addr_err_o = ~rst & mem_ce_i & lane_err;
    assign unused     = ^{if_addr_i[ADDR_W-1:RAM_AW+2], if_addr_i[1:0],
                          mem_addr_i[ADDR_W-1:RAM_AW+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            // Stores leave zero so the completion slot reports no load data.
            if (state_q == S_IDLE && mem_valid)
                rdata_q <= mem_we_i ? 32'h0 : lane_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ram_ce_o    = 1'b0;
        ram_we_o    = ~WriteEnable;
        ram_addr_o  = if_addr_i[RAM_AW+1:2];
        ram_sel_o   = 4'b1111;
        ram_wdata_o = 32'h0;
        if_inst_o   = 32'h0;
        mem_data_o  = 32'h0;
        stall_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    ram_ce_o    = ChipEnable;
                    ram_we_o    = mem_we_i ? WriteEnable : ~WriteEnable;
                    ram_addr_o  = mem_addr_i[RAM_AW+1:2];
                    ram_sel_o   = lane_sel;
                    ram_wdata_o = lane_wdata;
                    stall_req_o = 1'b1;
`ifdef WRITE_TURNAROUND_EN
                    state_d     = mem_we_i ? S_TURN : S_FETCH;
`else
                    state_d     = S_FETCH;
`endif
                end else begin
                    ram_ce_o  = if_ce_i;
                    if_inst_o = ram_rdata_i;
                end
            end
            S_FETCH: begin
                ram_ce_o   = if_ce_i;
                if_inst_o  = ram_rdata_i;
                mem_data_o = rdata_q;
                state_d    = S_IDLE;
            end
`ifdef WRITE_TURNAROUND_EN
            S_TURN: begin
                stall_req_o = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            ram_ce_o    = 1'b0;
            ram_we_o    = ~WriteEnable;
            stall_req_o = 1'b0;
            if_inst_o   = 32'h0;
            mem_data_o  = 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load results are queued at issue and checked at completion.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        mem_ce_i, mem_we_i;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic        addr_err_o, stall_req_o, ram_ce_o, ram_we_o;
    logic [19:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .RAM_AW(20)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .addr_err_o(addr_err_o), .stall_req_o(stall_req_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] word,
                           input logic [3:0] exp_sel, input logic [31:0] exp_data);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_op_i = op; mem_addr_i = addr;
        mem_data_i = 32'hCAFE_0000; ram_rdata_i = word;
        #1;
        chk("ld_sel", ram_sel_o, exp_sel);
        chk("ld_stall", stall_req_o, 1);
        chk("ld_ce", ram_ce_o, 1);
        chk("ld_we", ram_we_o, 0);
        chk("ld_addr", ram_addr_o, addr[21:2]);
        chk("ld_inst_blank", if_inst_o, 0);
        chk("ld_data_early", mem_data_o, 0);
        exp_q.push_back(exp_data);
        tick();
        ram_rdata_i = word ^ 32'h5555_5555;
        #1;
        chk("ld_done_stall", stall_req_o, 0);
        chk("ld_if_addr", ram_addr_o, if_addr_i[21:2]);
        chk("ld_if_sel", ram_sel_o, 4'hF);
        chk("ld_if_inst", if_inst_o, word ^ 32'h5555_5555);
        chk("ld_data", mem_data_o, exp_q.pop_front());
        mem_ce_i = 1'b0;
        tick();
    endtask

    task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] din,
                            input logic [3:0] exp_sel, input logic [31:0] exp_wdata);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_data_i = din;
        #1;
        chk("st_we", ram_we_o, 1);
        chk("st_ce", ram_ce_o, 1);
        chk("st_sel", ram_sel_o, exp_sel);
        chk("st_wdata", ram_wdata_o, exp_wdata);
        chk("st_addr", ram_addr_o, addr[21:2]);
        chk("st_stall", stall_req_o, 1);
        tick();
`ifdef WRITE_TURNAROUND_EN
        chk("st_turn_ce", ram_ce_o, 0);
        chk("st_turn_stall", stall_req_o, 1);
        tick();
`endif
        chk("st_done_stall", stall_req_o, 0);
        chk("st_done_we", ram_we_o, 0);
        chk("st_done_ce", ram_ce_o, 1);
        chk("st_done_data", mem_data_o, 0);
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        tick();
    endtask

    task automatic do_err(input logic we, input logic [2:0] op, input logic [31:0] addr);
        mem_ce_i = 1'b1; mem_we_i = we; mem_op_i = op; mem_addr_i = addr;
        #1;
        chk("err_flag", addr_err_o, 1);
        chk("err_ce", ram_ce_o, 1);
        chk("err_we", ram_we_o, 0);
        chk("err_sel", ram_sel_o, 4'hF);
        chk("err_stall", stall_req_o, 0);
        chk("err_data", mem_data_o, 0);
        tick();
        chk("err_still_idle", stall_req_o, 0);
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_op_i = MemOpW; mem_addr_i = 32'h0000_0006;
        mem_data_i = 32'h0; ram_rdata_i = 32'h2402_0005;
        #2;
        chk("rst_stall", stall_req_o, 0);
        chk("rst_ce", ram_ce_o, 0);
        chk("rst_we", ram_we_o, 0);
        chk("rst_mdata", mem_data_o, 0);
        chk("rst_inst", if_inst_o, 0);
        chk("rst_err", addr_err_o, 0);
        tick();
        rst = 1'b0; mem_ce_i = 1'b0;

        for (int i = 0; i < 3; i++) begin
            #1;
            chk("if_addr", ram_addr_o, 20'h00004);
            chk("if_inst", if_inst_o, 32'h2402_0005);
            chk("if_stall", stall_req_o, 0);
            chk("if_ce", ram_ce_o, 1);
            tick();
        end

        do_load(MemOpB,  32'h0000_0103, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
        do_load(MemOpHU, 32'h0000_0102, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
        do_load(MemOpH,  32'h0000_0102, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
        do_load(MemOpBU, 32'h0000_0101, 32'h80FF_1234, 4'b0010, 32'h0000_0012);
        do_load(MemOpH,  32'h0000_0100, 32'h80FF_1234, 4'b0011, 32'h0000_1234);
        do_load(MemOpB,  32'h0000_0100, 32'h80FF_1234, 4'b0001, 32'h0000_0034);
        do_load(MemOpW,  32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        do_store(MemOpB, 32'h0000_0201, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
        chk("sb_then_idle_stall", stall_req_o, 0);
        do_store(MemOpH, 32'h0000_0202, 32'h9999_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store(MemOpW, 32'h0000_0300, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F);

        do_err(1'b0, MemOpW,  32'h0000_0006);
        do_err(1'b0, MemOpHU, 32'h0000_0101);
        do_err(1'b0, 3'b011,  32'h0000_0100);
        do_err(1'b1, MemOpW,  32'h0000_0301);

        // IF idle during the fetch slot
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_op_i = MemOpW; mem_addr_i = 32'h0000_0104;
        ram_rdata_i = 32'h0102_0304;
        exp_q.push_back(32'h0102_0304);
        tick();
        if_ce_i = 1'b0;
        #1;
        chk("noif_ce", ram_ce_o, 0);
        chk("noif_stall", stall_req_o, 0);
        chk("noif_data", mem_data_o, exp_q.pop_front());
        mem_ce_i = 1'b0;
        tick();
        if_ce_i = 1'b1; ram_rdata_i = 32'h0000_1111;
        #1;
        chk("noif_back_idle_ce", ram_ce_o, 1);
        chk("noif_back_idle_inst", if_inst_o, 32'h0000_1111);
        tick();

        // reset while in the fetch slot
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_op_i = MemOpW; mem_addr_i = 32'h0000_0104;
        ram_rdata_i = 32'hDEAD_BEEF;
        tick();
        rst = 1'b1;
        #1;
        chk("rstf_stall", stall_req_o, 0);
        chk("rstf_ce", ram_ce_o, 0);
        chk("rstf_we", ram_we_o, 0);
        chk("rstf_mdata", mem_data_o, 0);
        chk("rstf_inst", if_inst_o, 0);
        chk("rstf_err", addr_err_o, 0);
        tick();
        rst = 1'b0; mem_ce_i = 1'b0; ram_rdata_i = 32'h2402_0005;
        #1;
        chk("rstf_state", dut.state_q, S_IDLE);
        chk("rstf_rdata_q", dut.rdata_q, 0);
        chk("rstf_if_inst", if_inst_o, 32'h2402_0005);
        chk("rstf_mdata_after", mem_data_o, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
